pixel_compositor: RTL and testbench
===================================

PIXEL_COMPOSITOR -- requirements
Module: pixel_compositor

Interface
REQ-001 Parameter ROM_LAT, default 1: clk cycles from x/y presentation to a layer's *_on/rgb output; legal range 1..4.
REQ-002 Parameter HOLD_FRAMES, default 8: frames held fully black between fade-out and fade-in.
REQ-003 Parameter BG_COLOR, default 12'h000: colour shown where no layer is on.
REQ-004 clk  in  1  system clock, the same clock used by all synchronous sprite/background ROMs.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 video_on, hsync_in, vsync_in  in  1 each  from vga_sync, aligned with the current x/y.
REQ-007 box_on, pipe_on, score_on, logo_on, sp_bg_on  in  1 each  layer hit flags, arriving ROM_LAT clk after x/y.
REQ-008 box_rgb, pipe_rgb, score_rgb, logo_rgb, bg_rgb  in  12 each  layer colours {R4,G4,B4}, aligned with the flags.
REQ-009 fade_req  in  1  single-clk pulse that requests a screen fade-out/fade-in cycle.
REQ-010 hsync, vsync  out  1 each  sync outputs aligned with rgb.
REQ-011 rgb  out  12  final pixel colour to the DAC pins.
REQ-012 fade_busy  out  1  high while the fade FSM is not in IDLE.

Function
REQ-013 The block SHALL delay video_on, hsync_in and vsync_in by ROM_LAT clk through a shift register so they align with the layer flags.
REQ-014 The block SHALL select the colour with fixed priority: score > logo > box > pipe > sp_bg > BG_COLOR.
REQ-015 The block SHALL force the selected colour to 12'h000 when the aligned video_on is 0.
REQ-016 The block SHALL register rgb, hsync and vsync once more after selection, giving a total latency of ROM_LAT+1 clk from vga_sync inputs to outputs, identical for all three.
REQ-017 The block SHALL detect frame boundaries as the 1->0 edge of the aligned vsync and produce one frame_tick per edge.
REQ-018 The fade FSM SHALL have states IDLE, FADE_OUT, HOLD and FADE_IN, with a 4-bit level register that is 15 in IDLE.
REQ-019 IDLE -> FADE_OUT: taken on fade_req; fade_req is ignored in every other state.
REQ-020 FADE_OUT: level decrements by 1 per frame_tick; when level reaches 0 the FSM enters HOLD and clears the hold counter.
REQ-021 HOLD: the hold counter increments per frame_tick; after HOLD_FRAMES ticks the FSM enters FADE_IN; with HOLD_FRAMES=0, HOLD lasts exactly 1 clk.
REQ-022 FADE_IN: level increments by 1 per frame_tick; when level reaches 15 the FSM returns to IDLE.
REQ-023 Level SHALL saturate at 0 and at 15 and never wrap.
REQ-024 Each channel c SHALL be scaled to (c*(level+1))>>4 using an 8-bit intermediate; level 15 passes the colour unchanged and level 0 yields 0.
REQ-025 Scaling SHALL be applied in the same stage as the priority mux, so latency is unchanged (REQ-016).
REQ-026 Level changes SHALL take effect only at frame_tick, so no frame shows mixed levels.
REQ-027 If fade_req coincides with frame_tick in IDLE, the FSM enters FADE_OUT and the first decrement occurs at the next frame_tick.

Reset
REQ-028 Asserting reset SHALL asynchronously clear rgb, hsync, vsync, the delay lines and the hold counter to 0.
REQ-029 Asserting reset SHALL asynchronously set level to 15 and the FSM to IDLE, so fade_busy=0.
REQ-030 Reset asserted mid-fade SHALL abort the fade with no residual dimming after release.
REQ-031 Outputs SHALL be valid ROM_LAT+1 clk after reset release; before that they hold their reset values.

Configuration
REQ-032 Macro COMPOSITOR_FADE_EN: when defined, the fade FSM, level register, scaling and fade_busy logic SHALL be compiled in as specified above.
REQ-033 When COMPOSITOR_FADE_EN is undefined, the block SHALL contain no fade logic: rgb is unscaled, fade_req is ignored and fade_busy is tied to 0.

Verification
REQ-034 ROM_LAT=1; pulse hsync_in at cycle 10 with box_on=1 and box_rgb=12'hF00 at cycle 11 -> hsync and rgb=12'hF00 both appear at cycle 12.
REQ-035 score_on=logo_on=box_on=sp_bg_on=1 with distinct colours -> rgb=score_rgb; all flags 0 -> rgb=BG_COLOR; video_on=0 -> rgb=12'h000.
REQ-036 FADE_EN, HOLD_FRAMES=2, bg_rgb=12'hFFF, fade_req pulse -> per-frame R nibble 15,14,...,0; 2 black frames; 0,1,...,15; fade_busy then drops to 0.
REQ-037 A second fade_req during FADE_OUT -> no restart; the level sequence is identical to REQ-036.
REQ-038 Reset asserted while level=7 -> the next valid frame is at level 15 with the FSM in IDLE; rgb=0 while reset is held.
REQ-039 FADE_EN undefined, fade_req pulse -> rgb unchanged and fade_busy=0 throughout.

Source files
------------

// File: rtl/pixel_compositor.sv
// pixel_compositor: final pixel stage of the video pipeline.
// Aligns the vga_sync timing with the layer ROM outputs, picks the top-most
// visible layer, blanks outside the active area and registers rgb/hsync/vsync.
// Optional screen fade-out/hold/fade-in is compiled in when the macro
// COMPOSITOR_FADE_EN is defined; without it rgb is unscaled, fade_req is
// ignored and fade_busy is tied low.
module pixel_compositor #(
    parameter int          ROM_LAT     = 1,
    parameter int          HOLD_FRAMES = 8,
    parameter logic [11:0] BG_COLOR    = 12'h000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        video_on,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        box_on,
    input  logic        pipe_on,
    input  logic        score_on,
    input  logic        logo_on,
    input  logic        sp_bg_on,
    input  logic [11:0] box_rgb,
    input  logic [11:0] pipe_rgb,
    input  logic [11:0] score_rgb,
    input  logic [11:0] logo_rgb,
    input  logic [11:0] bg_rgb,
    input  logic        fade_req,
    output logic        hsync,
    output logic        vsync,
    output logic [11:0] rgb,
    output logic        fade_busy
);

    // {video_on, hsync, vsync} per stage; the last stage lines up with the flags
    logic [2:0]  sync_dly_r [ROM_LAT];
    logic        video_al_s;
    logic        hsync_al_s;
    logic        vsync_al_s;
    logic [11:0] sel_rgb_s;
    logic [11:0] pix_s;
    logic [11:0] rgb_r;
    logic        hsync_r;
    logic        vsync_r;

    assign video_al_s = sync_dly_r[ROM_LAT-1][2];
    assign hsync_al_s = sync_dly_r[ROM_LAT-1][1];
    assign vsync_al_s = sync_dly_r[ROM_LAT-1][0];

    // Delay the sync signals by the ROM latency so they match the layer flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ROM_LAT; i++) begin
                sync_dly_r[i] <= 3'b000;
            end
        end else begin
            sync_dly_r[0] <= {video_on, hsync_in, vsync_in};
            for (int i = 1; i < ROM_LAT; i++) begin
                sync_dly_r[i] <= sync_dly_r[i-1];
            end
        end
    end

    // Fixed layer priority: score over logo over box over pipe over background
    always_comb begin
        sel_rgb_s = BG_COLOR;
        if (score_on) begin
            sel_rgb_s = score_rgb;
        end else if (logo_on) begin
            sel_rgb_s = logo_rgb;
        end else if (box_on) begin
            sel_rgb_s = box_rgb;
        end else if (pipe_on) begin
            sel_rgb_s = pipe_rgb;
        end else if (sp_bg_on) begin
            sel_rgb_s = bg_rgb;
        end else begin
            sel_rgb_s = BG_COLOR;
        end
    end

`ifdef COMPOSITOR_FADE_EN
    localparam int HOLD_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_FRAMES - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FADE_OUT = 2'd1,
        HOLD     = 2'd2,
        FADE_IN  = 2'd3
    } fade_state_t;

    fade_state_t       state_r;
    fade_state_t       state_nxt_s;
    logic [3:0]        level_r;
    logic [3:0]        level_nxt_s;
    logic [HOLD_W-1:0] hold_cnt_r;
    logic [HOLD_W-1:0] hold_nxt_s;
    logic              vs_prev_r;
    logic              frame_tick_s;
    logic              fade_busy_r;

    // Scale one 4-bit channel by (level+1)/16; level 15 is identity, 0 is black
    function automatic logic [3:0] scale_chan(input logic [3:0] c, input logic [3:0] lvl);
        logic [7:0] prod;
        prod = {4'b0000, c} * ({4'b0000, lvl} + 8'd1);
        return prod[7:4];
    endfunction

    function automatic logic [11:0] scale_rgb(input logic [11:0] c, input logic [3:0] lvl);
        return {scale_chan(c[11:8], lvl), scale_chan(c[7:4], lvl), scale_chan(c[3:0], lvl)};
    endfunction

    // Frame boundary is the falling edge of the aligned vsync
    assign frame_tick_s = vs_prev_r & ~vsync_al_s;

    // Remember the previous aligned vsync for edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vs_prev_r <= 1'b0;
        end else begin
            vs_prev_r <= vsync_al_s;
        end
    end

    // Fade next-state logic; level only moves on frame ticks so frames never mix levels
    always_comb begin
        state_nxt_s = state_r;
        level_nxt_s = level_r;
        hold_nxt_s  = hold_cnt_r;
        case (state_r)
            IDLE: begin
                level_nxt_s = 4'd15;
                if (fade_req) begin
                    state_nxt_s = FADE_OUT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            FADE_OUT: begin
                if (frame_tick_s) begin
                    if (level_r <= 4'd1) begin
                        level_nxt_s = 4'd0;
                        hold_nxt_s  = '0;
                        state_nxt_s = HOLD;
                    end else begin
                        level_nxt_s = level_r - 4'd1;
                    end
                end else begin
                    level_nxt_s = level_r;
                end
            end
            HOLD: begin
                if (HOLD_FRAMES == 0) begin
                    state_nxt_s = FADE_IN;
                end else if (frame_tick_s) begin
                    hold_nxt_s = hold_cnt_r + HOLD_ONE;
                    if (hold_cnt_r == HOLD_LAST) begin
                        state_nxt_s = FADE_IN;
                    end else begin
                        state_nxt_s = HOLD;
                    end
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            FADE_IN: begin
                if (frame_tick_s) begin
                    if (level_r >= 4'd14) begin
                        level_nxt_s = 4'd15;
                        state_nxt_s = IDLE;
                    end else begin
                        level_nxt_s = level_r + 4'd1;
                    end
                end else begin
                    level_nxt_s = level_r;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                level_nxt_s = 4'd15;
                hold_nxt_s  = '0;
            end
        endcase
    end

    // Fade state, level and hold counter registers; busy tracks the state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            level_r     <= 4'd15;
            hold_cnt_r  <= '0;
            fade_busy_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            level_r     <= level_nxt_s;
            hold_cnt_r  <= hold_nxt_s;
            fade_busy_r <= (state_nxt_s != IDLE);
        end
    end

    assign fade_busy = fade_busy_r;

    // Blank outside the active area, otherwise apply the fade level
    always_comb begin
        pix_s = 12'h000;
        if (video_al_s) begin
            pix_s = scale_rgb(sel_rgb_s, level_r);
        end else begin
            pix_s = 12'h000;
        end
    end
`else
    logic fade_req_unused_s;
    assign fade_req_unused_s = fade_req;
    assign fade_busy         = 1'b0;

    // Blank outside the active area
    always_comb begin
        pix_s = 12'h000;
        if (video_al_s) begin
            pix_s = sel_rgb_s;
        end else begin
            pix_s = 12'h000;
        end
    end
`endif

    // Output register: rgb and syncs leave together, ROM_LAT+1 clk after vga_sync
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rgb_r   <= 12'h000;
            hsync_r <= 1'b0;
            vsync_r <= 1'b0;
        end else begin
            rgb_r   <= pix_s;
            hsync_r <= hsync_al_s;
            vsync_r <= vsync_al_s;
        end
    end

    assign rgb   = rgb_r;
    assign hsync = hsync_r;
    assign vsync = vsync_r;

endmodule

// File: tb/tb_pixel_compositor.sv
// Bench for pixel_compositor: priority table, latency sequence, random
// stimulus against a reference model, and fade sequences when
// COMPOSITOR_FADE_EN is defined.
`timescale 1ns/1ps
module tb_pixel_compositor;

    localparam int          ROM_LAT = 1;
    localparam int          HOLD    = 2;
    localparam logic [11:0] BG      = 12'h0A5;

    logic        clk = 1'b0;
    logic        reset;
    logic        video_on, hsync_in, vsync_in;
    logic        box_on, pipe_on, score_on, logo_on, sp_bg_on;
    logic [11:0] box_rgb, pipe_rgb, score_rgb, logo_rgb, bg_rgb;
    logic        fade_req;
    logic        hsync, vsync, fade_busy;
    logic [11:0] rgb;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    pixel_compositor #(.ROM_LAT(ROM_LAT), .HOLD_FRAMES(HOLD), .BG_COLOR(BG)) dut (
        .clk(clk), .reset(reset),
        .video_on(video_on), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .box_on(box_on), .pipe_on(pipe_on), .score_on(score_on),
        .logo_on(logo_on), .sp_bg_on(sp_bg_on),
        .box_rgb(box_rgb), .pipe_rgb(pipe_rgb), .score_rgb(score_rgb),
        .logo_rgb(logo_rgb), .bg_rgb(bg_rgb),
        .fade_req(fade_req),
        .hsync(hsync), .vsync(vsync), .rgb(rgb), .fade_busy(fade_busy)
    );

    // layer index: 4 score, 3 logo, 2 box, 1 pipe, 0 background
    typedef struct packed {
        logic             vid;
        logic             hs;
        logic             vs;
        logic             fade;
        logic [4:0]       on;
        logic [4:0][11:0] col;
    } stim_t;

    typedef struct {
        string       name;
        stim_t       s;
        logic [11:0] exp;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input stim_t s);
        video_on  = s.vid;
        hsync_in  = s.hs;
        vsync_in  = s.vs;
        fade_req  = s.fade;
        score_on  = s.on[4];
        logo_on   = s.on[3];
        box_on    = s.on[2];
        pipe_on   = s.on[1];
        sp_bg_on  = s.on[0];
        score_rgb = s.col[4];
        logo_rgb  = s.col[3];
        box_rgb   = s.col[2];
        pipe_rgb  = s.col[1];
        bg_rgb    = s.col[0];
    endtask

    // Reference: highest-priority visible layer wins, blanking wins over everything
    function automatic logic [11:0] ref_pix(input stim_t sy, input stim_t ly);
        if (!sy.vid) return 12'h000;
        for (int i = 4; i >= 0; i--) begin
            if (ly.on[i]) return ly.col[i];
        end
        return BG;
    endfunction

`ifdef COMPOSITOR_FADE_EN
    // Expected fade level k frames after the request frame
    function automatic int exp_level(input int k);
        if (k == 0) return 15;
        if (k <= 15) return 15 - k;
        if (k <= 15 + HOLD) return 0;
        return k - 15 - HOLD;
    endfunction

    // One short frame: vsync high in slots 0..1, full-white background everywhere
    task automatic run_frame(input int req_slot, output logic [11:0] pix, output logic busy);
        stim_t s;
        pix  = 12'h000;
        busy = 1'b0;
        for (int sl = 0; sl < 8; sl++) begin
            s        = '0;
            s.vid    = 1'b1;
            s.vs     = (sl < 2);
            s.fade   = (sl == req_slot);
            s.on     = 5'b00001;
            s.col[0] = 12'hFFF;
            drive(s);
            tick();
            if (sl == 6) begin
                pix  = rgb;
                busy = fade_busy;
            end
        end
    endtask

    task automatic fade_run(input string tag, input int req_slot, input int second_frame);
        logic [11:0] p;
        logic        b;
        logic [3:0]  lvl;
        int          last;
        last = 30 + HOLD;
        for (int k = 0; k <= last; k++) begin
            run_frame((k == 0) ? req_slot : ((k == second_frame) ? 5 : -1), p, b);
            lvl = 4'(exp_level(k));
            chk($sformatf("%s_rgb_f%0d", tag, k), {20'd0, p}, {20'd0, lvl, lvl, lvl});
            chk($sformatf("%s_busy_f%0d", tag, k), {31'd0, b}, {31'd0, (k < last)});
        end
    endtask
`endif

    vec_t  vt[8];
    stim_t s;
    stim_t hist[300];

    initial begin
        // distinct colours for each layer
        s        = '0;
        s.col[4] = 12'h111;
        s.col[3] = 12'h222;
        s.col[2] = 12'h333;
        s.col[1] = 12'h444;
        s.col[0] = 12'h555;
        s.vid    = 1'b1;
        vt[0] = '{"all_on",    s, 12'h111};
        vt[0].s.on = 5'b11111;
        vt[1] = '{"logo_top",  s, 12'h222};
        vt[1].s.on = 5'b01111;
        vt[2] = '{"box_top",   s, 12'h333};
        vt[2].s.on = 5'b00111;
        vt[3] = '{"pipe_top",  s, 12'h444};
        vt[3].s.on = 5'b00011;
        vt[4] = '{"bg_only",   s, 12'h555};
        vt[4].s.on = 5'b00001;
        vt[5] = '{"none_on",   s, BG};
        vt[5].s.on = 5'b00000;
        vt[6] = '{"blank_all", s, 12'h000};
        vt[6].s.on = 5'b11101;
        vt[6].s.vid = 1'b0;
        vt[7] = '{"blank_none", s, 12'h000};
        vt[7].s.on = 5'b00000;
        vt[7].s.vid = 1'b0;

        // reset with live inputs: outputs must stay at reset values
        reset    = 1'b1;
        s        = '0;
        s.vid    = 1'b1;
        s.hs     = 1'b1;
        s.vs     = 1'b1;
        s.on     = 5'b00001;
        s.col[0] = 12'hFFF;
        drive(s);
        tick(); tick(); tick();
        chk("rst_rgb", {20'd0, rgb}, 32'd0);
        chk("rst_hsync", {31'd0, hsync}, 32'd0);
        chk("rst_vsync", {31'd0, vsync}, 32'd0);
        chk("rst_busy", {31'd0, fade_busy}, 32'd0);
        reset = 1'b0;
        tick();
        chk("post_rst1_rgb", {20'd0, rgb}, 32'd0);
        chk("post_rst1_hsync", {31'd0, hsync}, 32'd0);
        tick();
        chk("post_rst2_rgb", {20'd0, rgb}, 32'h0FFF);
        chk("post_rst2_hsync", {31'd0, hsync}, 32'd1);
        chk("post_rst2_vsync", {31'd0, vsync}, 32'd1);

        // priority / blanking table, inputs held steady
        for (int i = 0; i < 8; i++) begin
            drive(vt[i].s);
            tick();
            tick();
            chk(vt[i].name, {20'd0, rgb}, {20'd0, vt[i].exp});
        end

        // hsync pulse at cycle 10, box hit at cycle 11 -> both at cycle 12
        for (int sl = 0; sl < 13; sl++) begin
            s        = '0;
            s.vid    = 1'b1;
            s.hs     = (sl == 10);
            s.on     = (sl == 11) ? 5'b00100 : 5'b00000;
            s.col[2] = 12'hF00;
            drive(s);
            tick();
            if (sl + 1 == 11) begin
                chk("lat_c11_hsync", {31'd0, hsync}, 32'd0);
                chk("lat_c11_rgb", {20'd0, rgb}, {20'd0, BG});
            end else if (sl + 1 == 12) begin
                chk("lat_c12_hsync", {31'd0, hsync}, 32'd1);
                chk("lat_c12_rgb", {20'd0, rgb}, 32'h0F00);
            end else if (sl + 1 == 13) begin
                chk("lat_c13_hsync", {31'd0, hsync}, 32'd0);
            end
        end

        // random stimulus against the reference model
        for (int t = 0; t < 300; t++) begin
            s     = '0;
            s.vid = 1'($urandom);
            s.hs  = 1'($urandom);
            s.vs  = 1'($urandom);
            s.on  = 5'($urandom);
            for (int i = 0; i < 5; i++) begin
                s.col[i] = 12'($urandom);
            end
`ifdef COMPOSITOR_FADE_EN
            s.fade = 1'b0;
`else
            s.fade = ($urandom_range(0, 7) == 0);
`endif
            hist[t] = s;
            drive(s);
            tick();
            if (t >= 1) begin
                chk($sformatf("rnd_rgb_%0d", t), {20'd0, rgb}, {20'd0, ref_pix(hist[t-1], hist[t])});
                chk($sformatf("rnd_hsync_%0d", t), {31'd0, hsync}, {31'd0, hist[t-1].hs});
                chk($sformatf("rnd_vsync_%0d", t), {31'd0, vsync}, {31'd0, hist[t-1].vs});
                chk($sformatf("rnd_busy_%0d", t), {31'd0, fade_busy}, 32'd0);
            end
        end

`ifdef COMPOSITOR_FADE_EN
        begin
            logic [11:0] p;
            logic        b;
            run_frame(-1, p, b);
            run_frame(-1, p, b);
            chk("warm_rgb", {20'd0, p}, 32'h0FFF);
            chk("warm_busy", {31'd0, b}, 32'd0);
            // plain fade request mid-frame
            fade_run("fade", 5, -1);
            // request on the frame tick, then a second request during fade-out
            fade_run("fade_tick_req", 3, 5);

            // reset in the middle of a fade at level 7
            run_frame(5, p, b);
            for (int k = 1; k <= 8; k++) begin
                run_frame(-1, p, b);
            end
            chk("mid_fade_lvl7", {20'd0, p}, 32'h0777);
            s        = '0;
            s.vid    = 1'b1;
            s.on     = 5'b00001;
            s.col[0] = 12'hFFF;
            drive(s);
            tick();
            reset = 1'b1;
            #1;
            chk("fade_rst_rgb", {20'd0, rgb}, 32'd0);
            chk("fade_rst_busy", {31'd0, fade_busy}, 32'd0);
            tick(); tick();
            chk("fade_rst_hold_rgb", {20'd0, rgb}, 32'd0);
            reset = 1'b0;
            run_frame(-1, p, b);
            chk("after_rst_rgb", {20'd0, p}, 32'h0FFF);
            chk("after_rst_busy", {31'd0, b}, 32'd0);
        end
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
